// File: rtl/burst_guard_pkg.sv
// Shared definitions for the pulser output guard: state encoding, timer width, pulse counter width.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package burst_guard_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int PCNT_W    = 8;

    localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
    localparam logic [2:0] ST_DRV_P_ENC = 3'd1;
    localparam logic [2:0] ST_DRV_N_ENC = 3'd2;
    localparam logic [2:0] ST_DEAD_ENC  = 3'd3;
    localparam logic [2:0] ST_COOL_ENC  = 3'd4;
    localparam logic [2:0] ST_FAULT_ENC = 3'd5;
    localparam logic [2:0] ST_DAMP_ENC  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_DRV_P = ST_DRV_P_ENC,
        ST_DRV_N = ST_DRV_N_ENC,
        ST_DEAD  = ST_DEAD_ENC,
        ST_COOL  = ST_COOL_ENC,
        ST_FAULT = ST_FAULT_ENC,
        ST_DAMP  = ST_DAMP_ENC
    } state_t;

    // Saturating increment for the per-window pulse counter.
    function automatic logic [PCNT_W-1:0] sat_inc(input logic [PCNT_W-1:0] v);
        return (v == '1) ? v : v + PCNT_W'(1);
    endfunction

endpackage

// File: rtl/guard_timer.sv
// Loadable down-counter used for dead time, cool-down and damping intervals.
// Latency: load takes effect on the next edge; done is combinational from the count.
// Backpressure: none; counts freely and parks at zero.
module guard_timer #(
    parameter int CNT_W = 16
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // Load a new interval or count down towards zero and hold there.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/burst_output_guard.sv
// Pulser protection: exclusive P/N drive, dead time, on-time cap, pulse cap with cool-down, sticky fault (damping via BURST_GUARD_DAMP_EN).
// Latency: 1 cycle request-to-drive; all outputs registered.
// Backpressure: none; requests outside IDLE/DRV are ignored, conflicting requests latch a fault.
module burst_output_guard
    import burst_guard_pkg::*;
#(
    parameter int DEAD_CYC   = 4,
    parameter int MAX_ON_CYC = 64,
    parameter int MAX_PULSES = 32,
    parameter int COOL_CYC   = 1024,
    parameter int CNT_W      = CNT_W_DEF
`ifdef BURST_GUARD_DAMP_EN
    ,
    parameter int DAMP_CYC   = 8
`endif
) (
    input  logic              mainclk,
    input  logic              reset,
    input  logic              gate,
    input  logic              reqPos,
    input  logic              reqNeg,
    input  logic              clearFault,
    output logic              Burst_P,
    output logic              Burst_N,
    output logic              busy,
    output logic              fault,
    output logic [PCNT_W-1:0] pulseCnt
`ifdef BURST_GUARD_DAMP_EN
    ,
    output logic              damp
`endif
);

    state_t           state;
    logic [CNT_W-1:0] on_cnt;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;
    logic             own_req;
    logic             opp_req;
    logic             cool_due;
`ifdef BURST_GUARD_DAMP_EN
    logic             damp_pend;
`endif

    assign own_req  = (state == ST_DRV_N) ? reqNeg : reqPos;
    assign opp_req  = (state == ST_DRV_N) ? reqPos : reqNeg;
    assign cool_due = (32'(pulseCnt) >= MAX_PULSES);

    // Arm the shared timer: dead time is reloaded every drive cycle, the follow-on interval when dead time expires.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_DRV_P, ST_DRV_N: begin
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(DEAD_CYC - 1);
            end
            ST_DEAD: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
`ifdef BURST_GUARD_DAMP_EN
                    tmr_val  = cool_due ? CNT_W'(COOL_CYC - 1) : CNT_W'(DAMP_CYC - 1);
`else
                    tmr_val  = CNT_W'(COOL_CYC - 1);
`endif
                end
            end
            default: ;
        endcase
    end

    guard_timer #(.CNT_W(CNT_W)) u_timer (
        .core_clk (mainclk),
        .arst_n   (reset),
        .load     (tmr_load),
        .value    (tmr_val),
        .done     (tmr_done)
    );

    // Main FSM; outputs are registered alongside the state so they change on the same edge.
    always_ff @(posedge mainclk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            Burst_P  <= 1'b0;
            Burst_N  <= 1'b0;
            busy     <= 1'b0;
            fault    <= 1'b0;
            pulseCnt <= '0;
            on_cnt   <= '0;
`ifdef BURST_GUARD_DAMP_EN
            damp      <= 1'b0;
            damp_pend <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!gate) pulseCnt <= '0;
                    if (gate && reqPos && reqNeg) begin
                        state <= ST_FAULT;
                        fault <= 1'b1;
                        busy  <= 1'b1;
                    end else if (gate && reqPos) begin
                        state   <= ST_DRV_P;
                        Burst_P <= 1'b1;
                        busy    <= 1'b1;
                        on_cnt  <= CNT_W'(1);
                    end else if (gate && reqNeg) begin
                        state   <= ST_DRV_N;
                        Burst_N <= 1'b1;
                        busy    <= 1'b1;
                        on_cnt  <= CNT_W'(1);
                    end
                end
                ST_DRV_P, ST_DRV_N: begin
                    // A normal pulse end wins over an opposite request arriving on the same edge,
                    // so back-to-back alternation passes through dead time instead of faulting.
                    if (!own_req || !gate) begin
                        state    <= ST_DEAD;
                        Burst_P  <= 1'b0;
                        Burst_N  <= 1'b0;
                        pulseCnt <= sat_inc(pulseCnt);
`ifdef BURST_GUARD_DAMP_EN
                        damp_pend <= !gate;
`endif
                    end else if (opp_req || on_cnt == CNT_W'(MAX_ON_CYC)) begin
                        state   <= ST_FAULT;
                        Burst_P <= 1'b0;
                        Burst_N <= 1'b0;
                        fault   <= 1'b1;
                    end else begin
                        on_cnt <= on_cnt + CNT_W'(1);
                    end
                end
                ST_DEAD: begin
`ifdef BURST_GUARD_DAMP_EN
                    if (!gate) damp_pend <= 1'b1;
`endif
                    if (tmr_done) begin
`ifdef BURST_GUARD_DAMP_EN
                        damp_pend <= 1'b0;
                        if (cool_due) begin
                            state <= ST_COOL;
                        end else if (damp_pend || !gate) begin
                            state <= ST_DAMP;
                            damp  <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
`else
                        if (cool_due) begin
                            state <= ST_COOL;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
`endif
                    end
                end
                ST_COOL: begin
                    if (tmr_done) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        pulseCnt <= '0;
                    end
                end
`ifdef BURST_GUARD_DAMP_EN
                ST_DAMP: begin
                    if (tmr_done) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        damp  <= 1'b0;
                    end
                end
`endif
                ST_FAULT: begin
                    if (clearFault && !gate) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        fault    <= 1'b0;
                        pulseCnt <= '0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    Burst_P <= 1'b0;
                    Burst_N <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_output_guard.sv
// Randomized plus directed bench for burst_output_guard with a scoreboard fed by an abstract reference model.
// Latency: expected outputs are queued at drive time and checked one edge later.
// Backpressure: none; the driver runs one transaction per clock.
module tb_burst_output_guard;

    localparam int DEAD_CYC   = 4;
    localparam int MAX_ON_CYC = 64;
    localparam int MAX_PULSES = 32;
    localparam int COOL_CYC   = 1024;

    localparam int M_IDLE  = 0;
    localparam int M_DRIVE = 1;
    localparam int M_QUIET = 2;
    localparam int M_FAULT = 3;

    logic       mainclk = 1'b0;
    logic       reset   = 1'b1;
    logic       gate    = 1'b0;
    logic       reqPos  = 1'b0;
    logic       reqNeg  = 1'b0;
    logic       clearFault = 1'b0;
    logic       Burst_P;
    logic       Burst_N;
    logic       busy;
    logic       fault;
    logic [7:0] pulseCnt;
`ifdef BURST_GUARD_DAMP_EN
    logic       damp;
`endif

    int checks   = 0;
    int failures = 0;

    logic [11:0] exp_q[$];

    // Reference model state: a pulse is either being driven or followed by a quiet window
    // (dead time, stretched by the cool-down when the pulse cap has been reached).
    int m_mode  = M_IDLE;
    bit m_dirp  = 1'b0;
    int m_on    = 0;
    int m_quiet = 0;
    int m_pcnt  = 0;

    burst_output_guard dut (
        .mainclk    (mainclk),
        .reset      (reset),
        .gate       (gate),
        .reqPos     (reqPos),
        .reqNeg     (reqNeg),
        .clearFault (clearFault),
        .Burst_P    (Burst_P),
        .Burst_N    (Burst_N),
        .busy       (busy),
        .fault      (fault),
        .pulseCnt   (pulseCnt)
`ifdef BURST_GUARD_DAMP_EN
        ,
        .damp       (damp)
`endif
    );

    always #5 mainclk = ~mainclk;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit g, input bit rp, input bit rn, input bit clr,
                              input bit rst, output logic [11:0] e);
        bit own;
        bit opp;
        if (!rst) begin
            m_mode = M_IDLE;
            m_pcnt = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (!g) m_pcnt = 0;
                    if (g && rp && rn) begin
                        m_mode = M_FAULT;
                    end else if (g && (rp || rn)) begin
                        m_mode = M_DRIVE;
                        m_dirp = rp;
                        m_on   = 1;
                    end
                end
                M_DRIVE: begin
                    own = m_dirp ? rp : rn;
                    opp = m_dirp ? rn : rp;
                    if (!own || !g) begin
                        m_pcnt  = (m_pcnt < 255) ? m_pcnt + 1 : 255;
                        m_quiet = DEAD_CYC + ((m_pcnt >= MAX_PULSES) ? COOL_CYC : 0);
                        m_mode  = M_QUIET;
                    end else if (opp || m_on >= MAX_ON_CYC) begin
                        m_mode = M_FAULT;
                    end else begin
                        m_on++;
                    end
                end
                M_QUIET: begin
                    m_quiet--;
                    if (m_quiet == 0) begin
                        if (m_pcnt >= MAX_PULSES) m_pcnt = 0;
                        m_mode = M_IDLE;
                    end
                end
                default: begin
                    if (clr && !g) begin
                        m_mode = M_IDLE;
                        m_pcnt = 0;
                    end
                end
            endcase
        end
        e = {m_mode == M_DRIVE && m_dirp, m_mode == M_DRIVE && !m_dirp,
             m_mode != M_IDLE, m_mode == M_FAULT, 8'(m_pcnt)};
    endtask

    // One stimulus cycle: drive on the falling edge, queue the expected post-edge outputs.
    task automatic cyc(input bit g, input bit rp, input bit rn, input bit clr, input bit rst = 1'b1);
        logic [11:0] e;
        logic        prev_rst;
        @(negedge mainclk);
        prev_rst   = reset;
        gate       = g;
        reqPos     = rp;
        reqNeg     = rn;
        clearFault = clr;
        reset      = rst;
        model_step(g, rp, rn, clr, rst, e);
        exp_q.push_back(e);
        if (prev_rst && !rst) begin
            #1;
            chk("async_reset", {Burst_P, Burst_N, busy, fault, pulseCnt}, 12'h000);
        end
    endtask

    task automatic hold(input int n, input bit g, input bit rp, input bit rn, input bit clr);
        for (int i = 0; i < n; i++) cyc(g, rp, rn, clr);
    endtask

    // Monitor: compare DUT outputs shortly after each rising edge against the queued expectation.
    initial begin
        logic [11:0] e;
        forever begin
            @(posedge mainclk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("outputs", {Burst_P, Burst_N, busy, fault, pulseCnt}, e);
                chk("p_n_overlap", {11'b0, Burst_P & Burst_N}, 12'h000);
            end
        end
    end

    initial begin
        int kind;
        int len;
        bit g;
        #2 reset = 1'b0;
        #1;
        chk("reset_state", {Burst_P, Burst_N, busy, fault, pulseCnt}, 12'h000);
        hold(3, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single pulse of 10 cycles.
        hold(2, 1'b1, 1'b0, 1'b0, 1'b0);
        hold(10, 1'b1, 1'b1, 1'b0, 1'b0);
        hold(8, 1'b1, 1'b0, 1'b0, 1'b0);

        // Alternation P then N directly.
        hold(5, 1'b1, 1'b1, 1'b0, 1'b0);
        hold(10, 1'b1, 1'b0, 1'b1, 1'b0);
        hold(8, 1'b1, 1'b0, 1'b0, 1'b0);

        // Over-time pulse, then fault clear rules.
        hold(100, 1'b1, 1'b1, 1'b0, 1'b0);
        hold(3, 1'b1, 1'b0, 1'b0, 1'b1);
        hold(1, 1'b0, 1'b0, 1'b0, 1'b1);
        hold(3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Pulse cap and cool-down.
        for (int p = 0; p < MAX_PULSES; p++) begin
            hold(3, 1'b1, 1'b1, 1'b0, 1'b0);
            hold(6, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        hold(COOL_CYC + 20, 1'b1, 1'b0, 1'b0, 1'b0);
        hold(4, 1'b1, 1'b0, 1'b1, 1'b0);
        hold(6, 1'b1, 1'b0, 1'b0, 1'b0);

        // Conflict in IDLE.
        hold(1, 1'b1, 1'b1, 1'b1, 1'b0);
        hold(3, 1'b1, 1'b0, 1'b0, 1'b0);
        hold(2, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-pulse.
        hold(5, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        hold(3, 1'b1, 1'b1, 1'b0, 1'b0);
        hold(6, 1'b1, 1'b0, 1'b0, 1'b0);

        // Randomized segments.
        for (int s = 0; s < 400; s++) begin
            kind = $urandom_range(0, 9);
            len  = ($urandom_range(0, 15) == 0) ? $urandom_range(60, 70) : $urandom_range(1, 12);
            for (int c = 0; c < len; c++) begin
                g = ($urandom_range(0, 19) != 0);
                case (kind)
                    0, 1, 2, 3: cyc(g, 1'b1, 1'b0, 1'b0);
                    4, 5, 6:    cyc(g, 1'b0, 1'b1, 1'b0);
                    7:          cyc(g, ($urandom_range(0, 1) == 1), 1'b1, 1'b0);
                    8:          cyc(g, 1'b0, 1'b0, 1'b0);
                    default:    cyc(($urandom_range(0, 1) == 1), 1'b0, 1'b0, ($urandom_range(0, 1) == 1));
                endcase
            end
        end

        hold(4, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge mainclk);
        @(negedge mainclk);
        chk("queue_drained", 12'(exp_q.size()), 12'h000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
